nbit_serial_comparator: RTL and testbench

Parametrised magnitude comparator for two WIDTH-bit operands. It extends the fixed 2-bit combinational comparator to any width, adds a signed/unsigned mode, and adds a start/busy/done handshake. Operands are compared MSB-first, DIGIT bits per clock, and the comparison ends early at the first differing digit. It sits between operand registers and control logic that needs a registered greater/equal/less flag triple.

---
 rtl/nbit_serial_comparator.sv | 103 ++++++++++
 tb/tb_nbit_serial_comparator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nbit_serial_comparator.sv
// Serial magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, stopping at the first differing digit. Optional
// two's-complement mode. Results are registered gt/eq/lt with a done pulse.
`timescale 1ns/1ps
module nbit_serial_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}} >> 0;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] msb_mask;
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign msb_mask = signed_mode ? MSB_BIT : '0;
  assign da       = sa[WIDTH-1 -: DIGIT];
  assign db       = sb[WIDTH-1 -: DIGIT];

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a ^ msb_mask;
            sb    <= b ^ msb_mask;
            cnt   <= CW'(NDIG - 1);
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (da != db) begin
            gt    <= (da > db);
            lt    <= (da < db);
            eq    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == '0) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serial_comparator.sv
// Scoreboard bench for nbit_serial_comparator (WIDTH=8, DIGIT=2).
`timescale 1ns/1ps
module tb_nbit_serial_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;

  nbit_serial_comparator #(.WIDTH(8), .DIGIT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  flags;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc    = 0;
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [2:0]  prev   = 3'b000;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 5'b1, 5'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_flags"}, {2'b00, gt, eq, lt}, {2'b00, e.flags});
        check({e.name, "_latency"}, {4'b0, cyc == e.cyc}, 5'b1);
        check({e.name, "_busy_low"}, {4'b0, busy}, 5'b0);
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (!busy && !done) break;
      @(negedge clk);
    end
    check({nm, "_idle"}, {3'b0, busy, done}, 5'b0);
  endtask

  // Issue one compare; k is the digit on which the decision falls.
  task automatic do_cmp(input string nm, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input int unsigned k, input logic [2:0] f,
                        input bit disturb);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    e.flags = f; e.cyc = cyc + 1 + k; e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy"}, {4'b0, busy}, 5'b1);
    check({nm, "_hold"}, {2'b0, gt, eq, lt}, {2'b0, prev});
    if (disturb) begin
      @(negedge clk);
      a = 8'hFF; b = 8'h00; signed_mode = ~sm;
    end
    prev = f;
    wait_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int unsigned e0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, gt, eq, lt}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmp("t1_a5_5a",   8'hA5, 8'h5A, 1'b0, 1, F_GT, 1'b0);
    check("t1_flags_hold", {2'b0, gt, eq, lt}, {2'b0, F_GT});
    do_cmp("t2_eq_3c",   8'h3C, 8'h3C, 1'b0, 4, F_EQ, 1'b0);
    do_cmp("t3_signed",  8'h80, 8'h01, 1'b1, 1, F_LT, 1'b0);
    do_cmp("t3_unsigned",8'h80, 8'h01, 1'b0, 1, F_GT, 1'b0);
    do_cmp("t4_12_13",   8'h12, 8'h13, 1'b0, 4, F_LT, 1'b1);
    do_cmp("s_ff_01",    8'hFF, 8'h01, 1'b1, 1, F_LT, 1'b0);
    do_cmp("s_7f_80",    8'h7F, 8'h80, 1'b1, 1, F_GT, 1'b0);
    do_cmp("u_34_38",    8'h34, 8'h38, 1'b0, 3, F_LT, 1'b0);
    do_cmp("s_eq_80",    8'h80, 8'h80, 1'b1, 4, F_EQ, 1'b0);

    // Held start: accepts at E, E+6, E+12 (k=4, one compare per k+2 cycles).
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.flags = F_LT; e.cyc = e0 + 4 + 6 * i; e.name = $sformatf("t5_held%0d", i);
      sb_q.push_back(e);
    end
    while (cyc < e0 + 16) @(negedge clk);
    start = 1'b0;
    check("t5_flags", {2'b0, gt, eq, lt}, {2'b0, F_LT});
    prev = F_LT;
    wait_idle("t5");

    // Reset mid-compare: outputs clear immediately, the pending result is dropped.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    e.flags = F_LT; e.cyc = cyc + 5; e.name = "t6_aborted";
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("t6_async_clear", {busy, done, gt, eq, lt}, 5'b0);
    prev = 3'b000;
    @(negedge clk);
    check("t6_in_reset", {busy, done, gt, eq, lt}, 5'b0);
    rst_n = 1'b1;
    do_cmp("t6_01_02", 8'h01, 8'h02, 1'b0, 4, F_LT, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_empty", {4'b0, sb_q.size() != 0}, 5'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
